// File: rtl/disp_fmt.sv
// Seven-segment frame formatter: renders 32 digits into a shadow frame one per clock, then commits it atomically.
// Optional blink support is compiled in with `define DISP_FMT_BLINK_EN (adds blink_mask port and phase register).

// state    | meaning
// S_IDLE   | frame committed, waiting for a render request
// S_SNAP   | capture char/dp (and blink) inputs into the snapshot, idx = 0
// S_BUILD  | render snapshot digit idx into the shadow frame, idx++
// S_COMMIT | copy shadow to disp_data unless the capture strobe is active
module disp_fmt #(
    parameter int SEG_ACT_LOW  = 0,
    parameter int COMMIT_GUARD = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tsc_1pps,
    input  logic           tsc_1ppms,
    input  logic           upd,
    input  logic [159:0]   char_data,
    input  logic [31:0]    dp_data,
`ifdef DISP_FMT_BLINK_EN
    input  logic [31:0]    blink_mask,
`endif
    output logic [255:0]   disp_data,
    output logic           busy,
    output logic           frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_SNAP, S_BUILD, S_COMMIT} state_t;

    localparam logic [255:0] DISP_RST = (SEG_ACT_LOW != 0) ? {256{1'b1}} : '0;

    state_t         r_state;
    state_t         w_next;
    logic [4:0]     r_idx;
    logic           r_pend;
    logic [159:0]   r_snap_char;
    logic [31:0]    r_snap_dp;
    logic [31:0]    r_snap_blank;
    logic [255:0]   r_shadow;
    logic [255:0]   r_disp;
    logic           r_done;
    logic           w_req;
    logic           w_stall;
    logic           w_commit;
    logic [31:0]    w_blank;

`ifdef DISP_FMT_BLINK_EN
    logic           r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_phase <= 1'b0;
        else if (tsc_1pps)
            r_phase <= ~r_phase;
    end

    // A phase flip changes what must be displayed, so it re-renders like upd
    assign w_req   = upd | tsc_1pps;
    assign w_blank = r_phase ? blink_mask : 32'h0;
`else
    logic           w_unused_1pps;

    assign w_unused_1pps = tsc_1pps;
    assign w_req         = upd;
    assign w_blank       = 32'h0;
`endif

    function automatic logic [7:0] f_render(input logic [4:0] code, input logic dp, input logic blank);
        logic [6:0] seg;
        logic [7:0] byte_v;
        case (code)
            5'h00: seg = 7'h3F;
            5'h01: seg = 7'h06;
            5'h02: seg = 7'h5B;
            5'h03: seg = 7'h4F;
            5'h04: seg = 7'h66;
            5'h05: seg = 7'h6D;
            5'h06: seg = 7'h7D;
            5'h07: seg = 7'h07;
            5'h08: seg = 7'h7F;
            5'h09: seg = 7'h6F;
            5'h0A: seg = 7'h77;
            5'h0B: seg = 7'h7C;
            5'h0C: seg = 7'h39;
            5'h0D: seg = 7'h5E;
            5'h0E: seg = 7'h79;
            5'h0F: seg = 7'h71;
            5'h11: seg = 7'h40;
            default: seg = 7'h00;
        endcase
        byte_v = blank ? 8'h00 : {dp, seg};
        return (SEG_ACT_LOW != 0) ? ~byte_v : byte_v;
    endfunction

    assign w_stall = (COMMIT_GUARD != 0) && tsc_1ppms;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE:   if (w_req) w_next = S_SNAP;
            S_SNAP:   w_next = S_BUILD;
            S_BUILD:  if (r_idx == 5'd31) w_next = S_COMMIT;
            S_COMMIT: begin
                if (!w_stall) begin
                    w_commit = 1'b1;
                    w_next   = (r_pend || w_req) ? S_SNAP : S_IDLE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= 5'd0;
            r_pend       <= 1'b0;
            r_snap_char  <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '0;
            r_shadow     <= '0;
            r_disp       <= DISP_RST;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (r_state == S_SNAP) begin
                r_snap_char  <= char_data;
                r_snap_dp    <= dp_data;
                r_snap_blank <= w_blank;
                r_idx        <= 5'd0;
            end
            if (r_state == S_BUILD) begin
                r_shadow[8*r_idx +: 8] <= f_render(r_snap_char[5*r_idx +: 5],
                                                   r_snap_dp[r_idx], r_snap_blank[r_idx]);
                r_idx <= r_idx + 5'd1;
            end
            // Requests arriving while busy collapse into a single follow-up render
            if (w_commit) begin
                r_disp <= r_shadow;
                r_pend <= 1'b0;
            end else if (r_state != S_IDLE && w_req) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign disp_data  = r_disp;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_done;

endmodule

// File: tb/tb_disp_fmt.sv
// Directed bench for disp_fmt: active-high and active-low instances driven in parallel.
// Blink checks are included when DISP_FMT_BLINK_EN is defined.
module tb_disp_fmt;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           tsc_1pps;
    logic           tsc_1ppms;
    logic           upd;
    logic [159:0]   char_data;
    logic [31:0]    dp_data;
    logic [255:0]   disp_data, disp_inv;
    logic           busy, busy_inv;
    logic           frame_done, done_inv;
`ifdef DISP_FMT_BLINK_EN
    logic [31:0]    blink_mask;
`endif

    int n_chk = 0;
    int n_err = 0;

    localparam logic [6:0] FONT [32] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
        7'h00, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
        7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    disp_fmt #(.SEG_ACT_LOW(0), .COMMIT_GUARD(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .tsc_1pps(tsc_1pps), .tsc_1ppms(tsc_1ppms), .upd(upd),
        .char_data(char_data), .dp_data(dp_data),
`ifdef DISP_FMT_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .disp_data(disp_data), .busy(busy), .frame_done(frame_done));

    disp_fmt #(.SEG_ACT_LOW(1), .COMMIT_GUARD(1)) u_dut_inv (
        .clk(clk), .rst_n(rst_n), .tsc_1pps(tsc_1pps), .tsc_1ppms(tsc_1ppms), .upd(upd),
        .char_data(char_data), .dp_data(dp_data),
`ifdef DISP_FMT_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .disp_data(disp_inv), .busy(busy_inv), .frame_done(done_inv));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] exp_frame(input logic [159:0] ch, input logic [31:0] dp, input bit inv);
        logic [255:0] f;
        logic [7:0]   b;
        logic [4:0]   c;
        f = '0;
        for (int i = 0; i < 32; i++) begin
            c = ch[5*i +: 5];
            b = {dp[i], FONT[c]};
            if (inv) b = ~b;
            f[8*i +: 8] = b;
        end
        return f;
    endfunction

    // Pulse upd (or tsc_1pps), hold tsc_1ppms high for cycles tlo..thi, return cycles to frame_done
    task automatic wait_frame(input bit use_pps, input int tlo, input int thi, output int cyc);
        @(negedge clk);
        if (use_pps) tsc_1pps = 1'b1; else upd = 1'b1;
        @(negedge clk);
        tsc_1pps = 1'b0;
        upd      = 1'b0;
        cyc      = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (frame_done) break;
            tsc_1ppms = (cyc >= tlo && cyc <= thi);
        end
        tsc_1ppms = 1'b0;
        chk("frame_seen", 256'(frame_done), 256'(1'b1));
    endtask

    logic [159:0] ch_seq, ch_new;
    logic [255:0] f1, f2;
    int           cyc, nd;

    initial begin
        rst_n = 1'b0; tsc_1pps = 1'b0; tsc_1ppms = 1'b0; upd = 1'b0;
        char_data = '0; dp_data = '0;
`ifdef DISP_FMT_BLINK_EN
        blink_mask = '0;
`endif
        for (int i = 0; i < 32; i++) ch_seq[5*i +: 5] = 5'(i);
        for (int i = 0; i < 32; i++) ch_new[5*i +: 5] = 5'h03;

        repeat (3) @(negedge clk);
        chk("rst_disp", disp_data, '0);
        chk("rst_disp_inv", disp_inv, {256{1'b1}});
        chk("rst_busy", 256'(busy), '0);
        chk("rst_done", 256'(frame_done), '0);
        rst_n = 1'b1;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (frame_done) nd++;
        end
        chk("idle_no_done", 256'(nd), '0);

        // all eights with dp: every byte FF (00 inverted), 34-clock latency
        for (int i = 0; i < 32; i++) char_data[5*i +: 5] = 5'h08;
        dp_data = '1;
        wait_frame(1'b0, -1, -1, cyc);
        chk("latency", 256'(cyc), 256'(34));
        chk("eights", disp_data, {256{1'b1}});
        chk("eights_inv", disp_inv, '0);
        chk("done_inv", 256'(done_inv), 256'(1'b1));
        @(negedge clk);
        chk("done_pulse", 256'(frame_done), '0);
        chk("idle_busy", 256'(busy), '0);

        // every code once
        char_data = ch_seq;
        dp_data   = '0;
        wait_frame(1'b0, -1, -1, cyc);
        chk("font", disp_data, exp_frame(ch_seq, 32'h0, 1'b0));
        chk("font_inv", disp_inv, exp_frame(ch_seq, 32'h0, 1'b1));
        chk("byte31", 256'(disp_data[255:248]), 256'(8'h00));
        chk("byte17", 256'(disp_data[143:136]), 256'(8'h40));
        chk("byte10", 256'(disp_data[87:80]), 256'(8'h77));

        // capture strobe held over the commit: three stalls
        dp_data = 32'hA5C3_0F81;
        wait_frame(1'b0, 30, 35, cyc);
        chk("guard_latency", 256'(cyc), 256'(37));
        chk("guard_frame", disp_data, exp_frame(ch_seq, 32'hA5C3_0F81, 1'b0));

        // three requests during one render collapse to one follow-up
        dp_data = '0;
        nd = 0; f1 = '0; f2 = '0;
        @(negedge clk);
        upd = 1'b1;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (frame_done) begin
                nd++;
                if (nd == 1) f1 = disp_data; else f2 = disp_data;
            end
            upd = (c == 5 || c == 10 || c == 20);
            if (c == 5) char_data = ch_new;
        end
        chk("pend_count", 256'(nd), 256'(2));
        chk("pend_first", f1, exp_frame(ch_seq, 32'h0, 1'b0));
        chk("pend_second", f2, exp_frame(ch_new, 32'h0, 1'b0));

        // reset in the middle of a render
        char_data = ch_seq;
        dp_data   = '1;
        @(negedge clk);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        repeat (16) @(negedge clk);
        chk("mid_busy", 256'(busy), 256'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_disp", disp_data, '0);
        chk("mid_rst_inv", disp_inv, {256{1'b1}});
        chk("mid_rst_busy", 256'(busy), '0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_frame(1'b0, -1, -1, cyc);
        chk("post_rst_latency", 256'(cyc), 256'(34));
        chk("post_rst_frame", disp_data, exp_frame(ch_seq, 32'hFFFF_FFFF, 1'b0));

`ifdef DISP_FMT_BLINK_EN
        blink_mask = 32'h1;
        wait_frame(1'b1, -1, -1, cyc);
        chk("blink_off_d0", 256'(disp_data[7:0]), 256'(8'h00));
        chk("blink_off_d1", 256'(disp_data[15:8]), 256'(8'h86));
        chk("blink_off_inv", 256'(disp_inv[7:0]), 256'(8'hFF));
        wait_frame(1'b1, -1, -1, cyc);
        chk("blink_on_d0", 256'(disp_data[7:0]), 256'(8'hBF));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
